sram_port_arbiter: RTL and testbench
====================================

SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 SHALL have parameter WADR_W, default 19, meaning word-address width (SRAM halfword address is WADR_W+1 bits).
REQ-002 SHALL have port clk  input  1  single clock for all state.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports i_req in 1, i_adr in WADR_W, i_rdata out 32, i_ack out 1 for the instruction-fetch requester, which is read-only.
REQ-005 SHALL have ports d_req in 1, d_we in 1, d_adr in WADR_W, d_wdata in 32, d_rdata out 32, d_ack out 1 for the data requester.
REQ-006 SHALL have SRAM ports sram_adr out WADR_W+1, sram_dq_o out 16, sram_dq_i in 16, sram_dq_oe out 1, sram_we_n out 1, sram_oe_n out 1; tristating is done outside the block.
REQ-007 SHALL have port busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-008 SHALL implement the FSM IDLE -> LO -> HI -> DONE -> IDLE; each state lasts 1 cycle (see REQ-019 for the wait-state variant).
REQ-009 SHALL grant in IDLE only; the winner's address, we and wdata are latched at grant, so the requester only needs to hold req high until ack.
REQ-010 Arbitration SHALL be round-robin: a last_grant flag applies; if both ports request, the port not last granted wins; a single requester always wins.
REQ-011 Word mapping SHALL place the low halfword [15:0] at sram_adr={adr,0} (driven in LO) and the high halfword [31:16] at sram_adr={adr,1} (driven in HI).
REQ-012 Read: sram_oe_n SHALL be low in LO and HI; sram_dq_i SHALL be captured into the low half at the end of LO and into the high half at the end of HI.
REQ-013 Write: sram_dq_oe SHALL be high and sram_we_n low in LO and HI; sram_dq_o SHALL be wdata[15:0] in LO and wdata[31:16] in HI; sram_oe_n SHALL stay high.
REQ-014 In DONE, exactly one ack (i_ack or d_ack, the granted port) SHALL pulse high for 1 cycle; rdata of that port SHALL be valid then and held until that port's next read capture.
REQ-015 Latency SHALL be 3 cycles from the grant cycle (IDLE with req) to ack; back-to-back throughput SHALL be 1 access per 4 cycles.
REQ-016 A req still high in the cycle after its ack SHALL be treated as a new request; requests arriving during LO, HI or DONE SHALL wait for IDLE.
REQ-017 In IDLE: sram_we_n=1, sram_oe_n=1, sram_dq_oe=0, sram_adr held at its last value.

Reset
REQ-018 reset SHALL force the following on the next clk edge, aborting any access mid-operation without an ack: IDLE, last_grant=data (so the instruction port wins the first tie), i_ack=d_ack=0, i_rdata=d_rdata=0, sram_adr=0, sram_dq_o=0, sram_dq_oe=0, sram_we_n=1, sram_oe_n=1, busy=0.

Configuration
REQ-019 When macro SRAM_WAIT_STATE_EN is defined, LO and HI SHALL each last 2 cycles, with these rules:
- address and dq_o valid in both cycles;
- sram_we_n low only in the second cycle;
- read capture at the end of the second cycle;
- latency becomes 5 cycles and throughput 1 access per 6 cycles.
REQ-020 When SRAM_WAIT_STATE_EN is undefined, the timing of REQ-008..REQ-015 SHALL apply unchanged.

Verification
REQ-021 Read: the SRAM model holds 0x1234 at 0x00010 and 0xABCD at 0x00011; i_req with i_adr=0x00008 -> sram_adr=0x10 then 0x11, and i_ack pulses on cycle 3 with i_rdata=0xABCD1234.
REQ-022 Write: d_we=1, d_adr=0x00004, d_wdata=0xDEADBEEF -> dq_o=0xBEEF at adr 0x8 and 0xDEAD at adr 0x9 with we_n low in both; d_ack pulses, and a subsequent read returns 0xDEADBEEF.
REQ-023 Contention: i_req and d_req both held high from reset release -> grants in order I, D, I, D; acks 4 cycles apart; no ack is ever lost.
REQ-024 Reset in the HI cycle of a write -> next cycle we_n=1, dq_oe=0, busy=0, and no d_ack is issued.
REQ-025 With SRAM_WAIT_STATE_EN defined, repeat REQ-021 -> i_ack on cycle 5, and we_n is low for exactly 1 cycle per half in REQ-022.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// Two-port (instruction/data) round-robin arbiter onto a 16-bit asynchronous SRAM; each 32-bit word is two halfword accesses.
// Optional macro SRAM_WAIT_STATE_EN stretches each halfword phase to two cycles.
module sram_port_arbiter #(
    parameter int WADR_W = 19
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [WADR_W-1:0] i_adr,
    output logic [31:0]       i_rdata,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [WADR_W-1:0] d_adr,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              d_ack,
    output logic [WADR_W:0]   sram_adr,
    output logic [15:0]       sram_dq_o,
    input  logic [15:0]       sram_dq_i,
    output logic              sram_dq_oe,
    output logic              sram_we_n,
    output logic              sram_oe_n,
    output logic              busy
);

`ifdef SRAM_WAIT_STATE_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    state_t            state_q, state_d;
    logic              ws_q, ws_d;          // second cycle of a stretched half
    logic              last_d_q, last_d_d;  // data port held the previous grant
    logic              sel_d_q, sel_d_d;    // current access belongs to data port
    logic              we_q, we_d;
    logic [WADR_W-1:0] adr_q, adr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
    logic              i_ack_q, i_ack_d, d_ack_q, d_ack_d;
    logic [WADR_W:0]   sram_adr_q, sram_adr_d;
    logic [15:0]       sram_dq_o_q, sram_dq_o_d;
    logic              sram_dq_oe_q, sram_dq_oe_d;
    logic              sram_we_n_q, sram_we_n_d;
    logic              sram_oe_n_q, sram_oe_n_d;
    logic              win_d, hi_sel;

    always_comb begin
        state_d   = state_q;
        ws_d      = 1'b0;
        last_d_d  = last_d_q;
        sel_d_d   = sel_d_q;
        we_d      = we_q;
        adr_d     = adr_q;
        wdata_d   = wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        win_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    win_d    = d_req && (!i_req || !last_d_q);
                    last_d_d = win_d;
                    sel_d_d  = win_d;
                    we_d     = win_d && d_we;
                    adr_d    = win_d ? d_adr : i_adr;
                    wdata_d  = d_wdata;
                    state_d  = LO;
                end
            end
            LO: begin
                if (WAIT_EN && !ws_q) begin
                    ws_d = 1'b1;
                end else begin
                    state_d = HI;
                    if (!we_q) begin
                        if (sel_d_q) d_rdata_d[15:0] = sram_dq_i;
                        else         i_rdata_d[15:0] = sram_dq_i;
                    end
                end
            end
            HI: begin
                if (WAIT_EN && !ws_q) begin
                    ws_d = 1'b1;
                end else begin
                    state_d = DONE;
                    if (!we_q) begin
                        if (sel_d_q) d_rdata_d[31:16] = sram_dq_i;
                        else         i_rdata_d[31:16] = sram_dq_i;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // SRAM pins are registered from the next state so they are glitch-free.
    always_comb begin
        sram_adr_d   = sram_adr_q;
        sram_dq_o_d  = sram_dq_o_q;
        sram_dq_oe_d = 1'b0;
        sram_we_n_d  = 1'b1;
        sram_oe_n_d  = 1'b1;
        i_ack_d      = 1'b0;
        d_ack_d      = 1'b0;
        hi_sel       = (state_d == HI);

        if (state_d == LO || state_d == HI) begin
            sram_adr_d = {adr_d, hi_sel};
            if (we_d) begin
                sram_dq_o_d  = hi_sel ? wdata_d[31:16] : wdata_d[15:0];
                sram_dq_oe_d = 1'b1;
                sram_we_n_d  = WAIT_EN ? !ws_d : 1'b0;
            end else begin
                sram_oe_n_d  = 1'b0;
            end
        end else if (state_d == DONE) begin
            i_ack_d = !sel_d_d;
            d_ack_d = sel_d_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            ws_q         <= 1'b0;
            last_d_q     <= 1'b1;
            sel_d_q      <= 1'b0;
            we_q         <= 1'b0;
            adr_q        <= '0;
            wdata_q      <= '0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
            i_ack_q      <= 1'b0;
            d_ack_q      <= 1'b0;
            sram_adr_q   <= '0;
            sram_dq_o_q  <= '0;
            sram_dq_oe_q <= 1'b0;
            sram_we_n_q  <= 1'b1;
            sram_oe_n_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            ws_q         <= ws_d;
            last_d_q     <= last_d_d;
            sel_d_q      <= sel_d_d;
            we_q         <= we_d;
            adr_q        <= adr_d;
            wdata_q      <= wdata_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
            i_ack_q      <= i_ack_d;
            d_ack_q      <= d_ack_d;
            sram_adr_q   <= sram_adr_d;
            sram_dq_o_q  <= sram_dq_o_d;
            sram_dq_oe_q <= sram_dq_oe_d;
            sram_we_n_q  <= sram_we_n_d;
            sram_oe_n_q  <= sram_oe_n_d;
        end
    end

    assign i_rdata    = i_rdata_q;
    assign d_rdata    = d_rdata_q;
    assign i_ack      = i_ack_q;
    assign d_ack      = d_ack_q;
    assign sram_adr   = sram_adr_q;
    assign sram_dq_o  = sram_dq_o_q;
    assign sram_dq_oe = sram_dq_oe_q;
    assign sram_we_n  = sram_we_n_q;
    assign sram_oe_n  = sram_oe_n_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: transaction-level model plus SRAM model, directed cases and random traffic.
module tb_sram_port_arbiter;
    localparam int WADR_W = 19;
`ifdef SRAM_WAIT_STATE_EN
    localparam int H = 2;
`else
    localparam int H = 1;
`endif
    localparam int LAT = 2 * H + 1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [WADR_W-1:0] i_adr = '0, d_adr = '0;
    logic [31:0]       d_wdata = '0;
    logic [31:0]       i_rdata, d_rdata;
    logic              i_ack, d_ack;
    logic [WADR_W:0]   sram_adr;
    logic [15:0]       sram_dq_o;
    logic [15:0]       sram_dq_i = '0;
    logic              sram_dq_oe, sram_we_n, sram_oe_n, busy;

    sram_port_arbiter #(.WADR_W(WADR_W)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_adr(i_adr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_adr(d_adr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .sram_adr(sram_adr), .sram_dq_o(sram_dq_o), .sram_dq_i(sram_dq_i),
        .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // SRAM device model (halfword array) and reference word memory
    logic [15:0] mem16 [logic [WADR_W:0]];
    logic [31:0] ref_mem [logic [WADR_W-1:0]];

    function automatic logic [15:0] init16(input logic [WADR_W:0] a);
        return a[15:0] ^ 16'hC35A ^ {a[7:0], a[15:8]};
    endfunction

    function automatic logic [31:0] ref_word(input logic [WADR_W-1:0] w);
        if (ref_mem.exists(w)) return ref_mem[w];
        return {init16({w, 1'b1}), init16({w, 1'b0})};
    endfunction

    always @(posedge clk)
        if (!sram_we_n && sram_dq_oe) mem16[sram_adr] = sram_dq_o;

    always @(negedge clk) begin
        if (sram_oe_n)                  sram_dq_i <= 16'h5A5A;
        else if (mem16.exists(sram_adr)) sram_dq_i <= mem16[sram_adr];
        else                            sram_dq_i <= init16(sram_adr);
    end

    // Transaction model: an access occupies cycles 1..LAT after its grant cycle.
    bit                m_valid = 0, m_act = 0, m_last_d = 1, m_dport = 0, m_we = 0;
    int                m_k = 0;
    logic [WADR_W-1:0] m_adr = '0;
    logic [31:0]       m_wdata = '0, m_exp = '0;

    always @(negedge clk) begin
        int  half;
        bit  second;
        if (m_valid) begin
            chk("busy", busy, m_act);
            chk("i_ack", i_ack, m_act && m_k == LAT && !m_dport);
            chk("d_ack", d_ack, m_act && m_k == LAT && m_dport);
            if (m_act && m_k < LAT) begin
                half   = (m_k - 1) / H;
                second = ((m_k - 1) % H) == (H - 1);
                chk("sram_adr", sram_adr, {m_adr, half == 1});
                if (m_we) begin
                    chk("wr_dq_oe", sram_dq_oe, 1);
                    chk("wr_oe_n", sram_oe_n, 1);
                    chk("wr_we_n", sram_we_n, !second);
                    chk("wr_dq_o", sram_dq_o, half == 1 ? m_wdata[31:16] : m_wdata[15:0]);
                end else begin
                    chk("rd_oe_n", sram_oe_n, 0);
                    chk("rd_dq_oe", sram_dq_oe, 0);
                    chk("rd_we_n", sram_we_n, 1);
                end
            end else if (!m_act) begin
                chk("idle_we_n", sram_we_n, 1);
                chk("idle_oe_n", sram_oe_n, 1);
                chk("idle_dq_oe", sram_dq_oe, 0);
            end
            if (m_act && m_k == LAT && !m_we)
                chk("rdata", m_dport ? d_rdata : i_rdata, m_exp);
        end
        if (reset) begin
            m_valid = 1; m_act = 0; m_last_d = 1;
        end else if (m_valid) begin
            if (m_act) begin
                if (m_k == LAT) m_act = 0;
                else            m_k++;
            end else if (i_req || d_req) begin
                m_dport  = d_req && (!i_req || !m_last_d);
                m_last_d = m_dport;
                m_we     = m_dport && d_we;
                m_adr    = m_dport ? d_adr : i_adr;
                m_wdata  = d_wdata;
                if (m_we) ref_mem[m_adr] = m_wdata;
                else      m_exp = ref_word(m_adr);
                m_act = 1; m_k = 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 20 && busy; t++) tick();
        chk("wait_idle", busy, 0);
    endtask

    initial begin
        int acks, we_low, age_i, age_d, max_age;
        int ack_cyc [4];
        bit ack_prt [4];

        mem16[20'h10] = 16'h1234;
        mem16[20'h11] = 16'hABCD;
        ref_mem[19'h8] = 32'hABCD1234;

        tick(); tick();
        chk("rst_i_rdata", i_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_sram_adr", sram_adr, 0);
        chk("rst_dq_o", sram_dq_o, 0);
        chk("rst_we_n", sram_we_n, 1);
        chk("rst_oe_n", sram_oe_n, 1);
        chk("rst_dq_oe", sram_dq_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_acks", {i_ack, d_ack}, 0);
        reset = 1'b0;

        // Directed read of word 8
        i_req = 1; i_adr = 19'h8;
        for (int k = 1; k <= LAT; k++) begin
            tick();
            if (k == 1)     chk("rd_lo_adr", sram_adr, 20'h10);
            if (k == H + 1) chk("rd_hi_adr", sram_adr, 20'h11);
            if (k < LAT)    chk("rd_early_ack", i_ack, 0);
        end
        chk("rd_ack_lat", i_ack, 1);
        chk("rd_word", i_rdata, 32'hABCD1234);
        i_req = 0;

        // Directed write then readback
        wait_idle();
        d_req = 1; d_we = 1; d_adr = 19'h4; d_wdata = 32'hDEADBEEF;
        we_low = 0;
        for (int k = 1; k <= LAT; k++) begin
            tick();
            if (k < LAT && !sram_we_n) we_low++;
            if (k == H) begin
                chk("wr_lo_adr", sram_adr, 20'h8);
                chk("wr_lo_dq", sram_dq_o, 16'hBEEF);
            end
            if (k == 2 * H) begin
                chk("wr_hi_adr", sram_adr, 20'h9);
                chk("wr_hi_dq", sram_dq_o, 16'hDEAD);
            end
        end
        chk("wr_ack", d_ack, 1);
        chk("wr_we_low_cycles", we_low, 2);
        d_req = 0; d_we = 0;
        wait_idle();
        i_req = 1; i_adr = 19'h4;
        for (int k = 1; k <= LAT; k++) tick();
        chk("rb_ack", i_ack, 1);
        chk("rb_word", i_rdata, 32'hDEADBEEF);
        i_req = 0;

        // Contention from reset release
        wait_idle();
        reset = 1; i_req = 1; i_adr = 19'h1; d_req = 1; d_we = 0; d_adr = 19'h2;
        tick();
        reset = 0;
        acks = 0;
        for (int t = 1; t <= 4 * (LAT + 1) + 4 && acks < 4; t++) begin
            tick();
            if (i_ack || d_ack) begin
                ack_cyc[acks] = t; ack_prt[acks] = d_ack; acks++;
            end
        end
        i_req = 0; d_req = 0;
        chk("cont_acks", acks, 4);
        if (acks == 4) begin
            chk("cont_first_lat", ack_cyc[0], LAT);
            for (int j = 0; j < 4; j++) chk("cont_order", ack_prt[j], j % 2);
            for (int j = 1; j < 4; j++) chk("cont_spacing", ack_cyc[j] - ack_cyc[j-1], LAT + 1);
        end

        // Reset during the high half of a write
        wait_idle();
        d_req = 1; d_we = 1; d_adr = 19'h40; d_wdata = 32'h12345678;
        for (int k = 1; k <= 2 * H; k++) tick();
        reset = 1;
        tick();
        chk("abort_we_n", sram_we_n, 1);
        chk("abort_dq_oe", sram_dq_oe, 0);
        chk("abort_busy", busy, 0);
        chk("abort_d_ack", d_ack, 0);
        reset = 0; d_req = 0; d_we = 0;
        for (int k = 0; k <= LAT; k++) begin
            tick();
            chk("abort_no_ack", d_ack, 0);
        end

        // Random traffic from both requesters
        age_i = 0; age_d = 0; max_age = 0;
        for (int c = 0; c < 1500; c++) begin
            if (i_req && i_ack) begin
                i_req = 1'($urandom % 2); i_adr = 19'($urandom % 16); age_i = 0;
            end else if (!i_req && ($urandom % 3) == 0) begin
                i_req = 1; i_adr = 19'($urandom % 16);
            end
            if (d_req && d_ack) begin
                d_req = 1'($urandom % 2); age_d = 0;
                d_we = 1'($urandom % 2); d_adr = 19'($urandom % 16); d_wdata = $urandom;
            end else if (!d_req && ($urandom % 3) == 0) begin
                d_req = 1; d_we = 1'($urandom % 2); d_adr = 19'($urandom % 16); d_wdata = $urandom;
            end
            age_i = i_req ? age_i + 1 : 0;
            age_d = d_req ? age_d + 1 : 0;
            if (age_i > max_age) max_age = age_i;
            if (age_d > max_age) max_age = age_d;
            tick();
        end
        chk("max_wait", max_age <= 2 * (LAT + 1) + 1, 1);
        i_req = 0; d_req = 0;
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
